// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction ROM
// and loads the IF/ID register, with stall, redirect, interrupt entry and halt/resume.
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] INT_VECTOR = 32'h0000_0800,
    parameter int          ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              int_req,
    input  logic              halt_req,
    input  logic              resume,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_sel,
    input  logic [31:0]       rom_data,
    output logic [31:0]       ifid_inst,
    output logic [31:0]       ifid_pc,
    output logic [31:0]       ifid_pc4,
    output logic              ifid_valid,
    output logic [31:0]       epc,
    output logic              int_ack,
    output logic [31:0]       fetch_count,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] next_seq(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    // The ROM answers in the same cycle, so the address comes straight from the PC.
    assign rom_addr = pc[ADDR_W+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BOOT;
            pc          <= RESET_PC;
            rom_sel     <= 1'b0;
            halted      <= 1'b0;
            ifid_inst   <= 32'd0;
            ifid_pc     <= 32'd0;
            ifid_pc4    <= 32'd0;
            ifid_valid  <= 1'b0;
            epc         <= 32'd0;
            int_ack     <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            int_ack <= 1'b0;
            case (state)
                ST_BOOT: begin
                    state   <= ST_RUN;
                    rom_sel <= 1'b1;
                end
                ST_RUN: begin
                    if (int_req) begin
                        // A redirect already in flight is the instruction we must return to.
                        pc         <= word_align(INT_VECTOR);
                        epc        <= branch_taken ? branch_target : pc;
                        int_ack    <= 1'b1;
                        ifid_valid <= 1'b0;
                    end else if (branch_taken) begin
                        pc         <= word_align(branch_target);
                        ifid_valid <= 1'b0;
                    end else if (halt_req) begin
                        // PC is left untouched so the squashed fetch is repeated on resume.
                        state      <= ST_HALT;
                        rom_sel    <= 1'b0;
                        halted     <= 1'b1;
                        ifid_valid <= 1'b0;
                    end else if (!stall) begin
                        ifid_inst   <= rom_data;
                        ifid_pc     <= pc;
                        ifid_pc4    <= next_seq(pc);
                        ifid_valid  <= 1'b1;
                        pc          <= next_seq(pc);
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                ST_HALT: begin
                    if (int_req) begin
                        pc      <= word_align(INT_VECTOR);
                        epc     <= pc;
                        int_ack <= 1'b1;
                        state   <= ST_RUN;
                        rom_sel <= 1'b1;
                        halted  <= 1'b0;
                    end else if (resume) begin
                        state   <= ST_RUN;
                        rom_sel <= 1'b1;
                        halted  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_BOOT;
                    rom_sel <= 1'b0;
                    halted  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, async-reset/wrap sequences and
// randomized traffic checked against a behavioural fetch model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, branch_taken = 1'b0, int_req = 1'b0;
    logic        halt_req = 1'b0, resume = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [9:0]  rom_addr;
    logic        rom_sel;
    logic [31:0] rom_data;
    logic [31:0] ifid_inst, ifid_pc, ifid_pc4, epc, fetch_count;
    logic        ifid_valid, int_ack, halted;
    logic [31:0] salt = 32'd0;

    int checks = 0;
    int errors = 0;

    inst_fetch #(.RESET_PC(32'h0), .INT_VECTOR(32'h800), .ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .int_req(int_req), .halt_req(halt_req),
        .resume(resume), .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_data(rom_data),
        .ifid_inst(ifid_inst), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
        .ifid_valid(ifid_valid), .epc(epc), .int_ack(int_ack),
        .fetch_count(fetch_count), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [9:0] a, input logic [31:0] s);
        return 32'(a) + s;
    endfunction

    assign rom_data = rom_sel ? rom_word(rom_addr, salt) : 32'hFFFF_FFFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic b, input logic [31:0] t,
                          input logic i, input logic h, input logic r);
        stall = s; branch_taken = b; branch_target = t;
        int_req = i; halt_req = h; resume = r;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_rom_sel"}, 32'(rom_sel), 32'd0);
        chk({tag, "_ifid_inst"}, ifid_inst, 32'd0);
        chk({tag, "_ifid_pc"}, ifid_pc, 32'd0);
        chk({tag, "_ifid_pc4"}, ifid_pc4, 32'd0);
        chk({tag, "_ifid_valid"}, 32'(ifid_valid), 32'd0);
        chk({tag, "_epc"}, epc, 32'd0);
        chk({tag, "_int_ack"}, 32'(int_ack), 32'd0);
        chk({tag, "_fetch_count"}, fetch_count, 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    typedef struct {
        logic        stall, br;
        logic [31:0] tgt;
        logic        intr, halt, res;
        logic [9:0]  addr;
        logic        sel, v;
        logic [31:0] ipc, inst, cnt;
        logic        ack;
        logic [31:0] epc;
        logic        hlt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                                input logic i, input logic h, input logic r,
                                input logic [9:0] a, input logic sl, input logic v,
                                input logic [31:0] ipc, input logic [31:0] inst,
                                input logic [31:0] cnt, input logic ack,
                                input logic [31:0] e, input logic hl);
        vec_t x;
        x.stall = s; x.br = b; x.tgt = t; x.intr = i; x.halt = h; x.res = r;
        x.addr = a; x.sel = sl; x.v = v; x.ipc = ipc; x.inst = inst; x.cnt = cnt;
        x.ack = ack; x.epc = e; x.hlt = hl;
        return x;
    endfunction

    // Behavioural model: mode 0 = boot, 1 = running, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc, m_inst, m_ipc, m_pc4, m_cnt, m_epc;
    logic        m_v, m_ack;

    task automatic model_reset();
        m_mode = 0; m_pc = 32'h0; m_inst = 0; m_ipc = 0; m_pc4 = 0;
        m_cnt = 0; m_epc = 0; m_v = 0; m_ack = 0;
    endtask

    task automatic model_step();
        m_ack = 1'b0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (int_req) begin
            m_epc = (m_mode == 1 && branch_taken) ? branch_target : m_pc;
            m_pc  = 32'h800;
            m_ack = 1'b1;
            m_v   = 1'b0;
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (branch_taken) begin
                m_pc = branch_target & ~32'd3;
                m_v  = 1'b0;
            end else if (halt_req) begin
                m_mode = 2;
                m_v    = 1'b0;
            end else if (!stall) begin
                m_inst = rom_word(10'((m_pc / 4) % 1024), salt);
                m_ipc  = m_pc;
                m_pc4  = m_pc + 4;
                m_v    = 1'b1;
                m_pc   = m_pc + 4;
                m_cnt  = m_cnt + 1;
            end
        end else if (resume) begin
            m_mode = 1;
        end
    endtask

    initial begin
        // 1-5: free run, stall, redirect during stall, int+branch, halt/resume, int in halt.
        tbl.push_back(mk(0,0,0,0,0,0, 10'h0,  1,0, 32'h0,   32'h0,   0, 0, 32'h0,   0));
        tbl.push_back(mk(0,0,0,0,0,0, 10'h1,  1,1, 32'h0,   32'h0,   1, 0, 32'h0,   0));
        tbl.push_back(mk(0,0,0,0,0,0, 10'h2,  1,1, 32'h4,   32'h1,   2, 0, 32'h0,   0));
        tbl.push_back(mk(0,0,0,0,0,0, 10'h3,  1,1, 32'h8,   32'h2,   3, 0, 32'h0,   0));
        tbl.push_back(mk(0,0,0,0,0,0, 10'h4,  1,1, 32'hC,   32'h3,   4, 0, 32'h0,   0));
        tbl.push_back(mk(1,0,0,0,0,0, 10'h4,  1,1, 32'hC,   32'h3,   4, 0, 32'h0,   0));
        tbl.push_back(mk(1,0,0,0,0,0, 10'h4,  1,1, 32'hC,   32'h3,   4, 0, 32'h0,   0));
        tbl.push_back(mk(1,0,0,0,0,0, 10'h4,  1,1, 32'hC,   32'h3,   4, 0, 32'h0,   0));
        tbl.push_back(mk(0,0,0,0,0,0, 10'h5,  1,1, 32'h10,  32'h4,   5, 0, 32'h0,   0));
        tbl.push_back(mk(0,0,0,0,0,0, 10'h6,  1,1, 32'h14,  32'h5,   6, 0, 32'h0,   0));
        tbl.push_back(mk(0,0,0,0,0,0, 10'h7,  1,1, 32'h18,  32'h6,   7, 0, 32'h0,   0));
        tbl.push_back(mk(0,0,0,0,0,0, 10'h8,  1,1, 32'h1C,  32'h7,   8, 0, 32'h0,   0));
        tbl.push_back(mk(1,1,32'h103,0,0,0, 10'h40, 1,0, 32'h1C, 32'h7, 8, 0, 32'h0, 0));
        tbl.push_back(mk(0,0,0,0,0,0, 10'h41, 1,1, 32'h100, 32'h40,  9, 0, 32'h0,   0));
        tbl.push_back(mk(0,1,32'h30,0,0,0, 10'hC, 1,0, 32'h100, 32'h40, 9, 0, 32'h0, 0));
        tbl.push_back(mk(0,1,32'h40,1,0,0, 10'h200, 1,0, 32'h100, 32'h40, 9, 1, 32'h40, 0));
        tbl.push_back(mk(0,0,0,0,0,0, 10'h201, 1,1, 32'h800, 32'h200, 10, 0, 32'h40, 0));
        tbl.push_back(mk(0,1,32'h14,0,0,0, 10'h5, 1,0, 32'h800, 32'h200, 10, 0, 32'h40, 0));
        tbl.push_back(mk(0,0,0,0,1,0, 10'h5,  0,0, 32'h800, 32'h200, 10, 0, 32'h40, 1));
        tbl.push_back(mk(1,1,32'h200,0,1,0, 10'h5, 0,0, 32'h800, 32'h200, 10, 0, 32'h40, 1));
        tbl.push_back(mk(0,0,0,0,0,1, 10'h5,  1,0, 32'h800, 32'h200, 10, 0, 32'h40, 0));
        tbl.push_back(mk(0,0,0,0,0,0, 10'h6,  1,1, 32'h14,  32'h5,  11, 0, 32'h40, 0));
        tbl.push_back(mk(0,1,32'h14,0,0,0, 10'h5, 1,0, 32'h14, 32'h5, 11, 0, 32'h40, 0));
        tbl.push_back(mk(0,0,0,0,1,0, 10'h5,  0,0, 32'h14,  32'h5,  11, 0, 32'h40, 1));
        tbl.push_back(mk(0,0,0,1,0,0, 10'h200, 1,0, 32'h14, 32'h5,  11, 1, 32'h14, 0));
        tbl.push_back(mk(0,0,0,0,0,0, 10'h201, 1,1, 32'h800, 32'h200, 12, 0, 32'h14, 0));
        tbl.push_back(mk(0,0,0,0,0,0, 10'h202, 1,1, 32'h804, 32'h201, 13, 0, 32'h14, 0));
        tbl.push_back(mk(0,0,0,1,0,0, 10'h200, 1,0, 32'h804, 32'h201, 13, 1, 32'h808, 0));
        tbl.push_back(mk(0,0,0,1,0,0, 10'h200, 1,0, 32'h804, 32'h201, 13, 1, 32'h800, 0));
        tbl.push_back(mk(0,0,0,0,0,0, 10'h201, 1,1, 32'h800, 32'h200, 14, 0, 32'h800, 0));
        tbl.push_back(mk(1,0,0,0,1,0, 10'h201, 0,0, 32'h800, 32'h200, 14, 0, 32'h800, 1));
        tbl.push_back(mk(0,0,0,1,0,1, 10'h200, 1,0, 32'h800, 32'h200, 14, 1, 32'h804, 0));
        tbl.push_back(mk(0,0,0,0,0,0, 10'h201, 1,1, 32'h800, 32'h200, 15, 0, 32'h804, 0));

        step();
        step();
        chk_reset_vals("reset");
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            set_in(tbl[k].stall, tbl[k].br, tbl[k].tgt, tbl[k].intr, tbl[k].halt, tbl[k].res);
            step();
            chk($sformatf("v%0d_rom_addr", k), 32'(rom_addr), 32'(tbl[k].addr));
            chk($sformatf("v%0d_rom_sel", k), 32'(rom_sel), 32'(tbl[k].sel));
            chk($sformatf("v%0d_valid", k), 32'(ifid_valid), 32'(tbl[k].v));
            chk($sformatf("v%0d_ifid_pc", k), ifid_pc, tbl[k].ipc);
            chk($sformatf("v%0d_ifid_inst", k), ifid_inst, tbl[k].inst);
            chk($sformatf("v%0d_count", k), fetch_count, tbl[k].cnt);
            chk($sformatf("v%0d_int_ack", k), 32'(int_ack), 32'(tbl[k].ack));
            chk($sformatf("v%0d_epc", k), epc, tbl[k].epc);
            chk($sformatf("v%0d_halted", k), 32'(halted), 32'(tbl[k].hlt));
            if (tbl[k].v)
                chk($sformatf("v%0d_ifid_pc4", k), ifid_pc4, tbl[k].ipc + 32'd4);
        end

        // Asynchronous reset in mid-cycle at pc=0x7FC.
        set_in(0, 1, 32'h7FC, 0, 0, 0);
        step();
        chk("pre_async_rom_addr", 32'(rom_addr), 32'h1FF);
        set_in(0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        #1;
        rst_n = 1'b1;
        step();
        chk("boot_rom_sel", 32'(rom_sel), 32'd1);
        chk("boot_valid", 32'(ifid_valid), 32'd0);
        step();
        chk("restart_ifid_pc", ifid_pc, 32'h0);
        chk("restart_valid", 32'(ifid_valid), 32'd1);
        chk("restart_count", fetch_count, 32'd1);

        // ROM address wrap when pc crosses 0xFFC -> 0x1000.
        set_in(0, 1, 32'hFFC, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        step();
        chk("wrap_ifid_pc", ifid_pc, 32'hFFC);
        chk("wrap_ifid_inst", ifid_inst, 32'h3FF);
        chk("wrap_ifid_pc4", ifid_pc4, 32'h1000);
        chk("wrap_rom_addr", 32'(rom_addr), 32'h0);

        // Randomized traffic against the behavioural model.
        rst_n = 1'b0;
        salt = $urandom;
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 800; n++) begin
            stall         = ($urandom_range(0, 99) < 25);
            branch_taken  = ($urandom_range(0, 99) < 10);
            branch_target = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFC)
                                                        : 32'($urandom_range(0, 1023) * 4);
            int_req       = ($urandom_range(0, 99) < 5);
            halt_req      = ($urandom_range(0, 99) < 6);
            resume        = ($urandom_range(0, 99) < 30);
            model_step();
            step();
            chk("rnd_rom_addr", 32'(rom_addr), 32'(m_pc[11:2]));
            chk("rnd_rom_sel", 32'(rom_sel), 32'(m_mode == 1));
            chk("rnd_halted", 32'(halted), 32'(m_mode == 2));
            chk("rnd_valid", 32'(ifid_valid), 32'(m_v));
            chk("rnd_ifid_inst", ifid_inst, m_inst);
            chk("rnd_ifid_pc", ifid_pc, m_ipc);
            chk("rnd_ifid_pc4", ifid_pc4, m_pc4);
            chk("rnd_epc", epc, m_epc);
            chk("rnd_int_ack", 32'(int_ack), 32'(m_ack));
            chk("rnd_count", fetch_count, m_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch stage of the pipelined CPU. It owns the program counter and drives the word address and select of the combinational instruction ROM, which returns data in the same cycle. It also registers the fetched word into the IF/ID pipeline register. It handles stall, branch/jump redirect, interrupt vectoring with EPC capture, and halt/resume.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset.
INT_VECTOR, 32'h0000_0800, interrupt handler entry address.
ADDR_W, 10, ROM word-address width.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
stall  in  1  hazard unit: hold PC and IF/ID.
branch_taken  in  1  EX-stage redirect request.
branch_target  in  32  redirect byte address.
int_req  in  1  interrupt request, level-sampled.
halt_req  in  1  enter HALT.
resume  in  1  leave HALT.
rom_addr  out  ADDR_W  ROM word address = pc[ADDR_W+1:2].
rom_sel  out  1  ROM select.
rom_data  in  32  ROM read data, combinational from rom_addr/rom_sel.
ifid_inst  out  32  registered instruction.
ifid_pc  out  32  byte address of ifid_inst.
ifid_pc4  out  32  ifid_pc + 4.
ifid_valid  out  1  IF/ID holds a real instruction.
epc  out  32  return address captured at interrupt entry.
int_ack  out  1  one-cycle pulse when an interrupt is taken.
fetch_count  out  32  number of instructions loaded into IF/ID.
halted  out  1  high in HALT state.

Behaviour:
- Reset, async on rst_n low:
  - pc=RESET_PC, state=BOOT.
  - ifid_inst=0, ifid_pc=0, ifid_pc4=0, ifid_valid=0.
  - epc=0, int_ack=0, fetch_count=0, halted=0.
- States:
  - BOOT: rom_sel=0, no fetch. Next state is always RUN.
  - RUN: rom_sel=1.
  - HALT: rom_sel=0, halted=1.
- rom_addr is always driven from pc; there is no ROM read latency.
- All redirect targets load PC with bits [1:0] forced to 0. PC increment is +4 modulo 2^32. rom_addr wraps naturally within the ROM.
- RUN, per cycle, priority highest first:
  1. int_req=1: pc<=INT_VECTOR; epc<=branch_taken ? branch_target : pc; int_ack<=1; ifid_valid<=0. The current fetch is squashed. Overrides stall and branch.
  2. branch_taken=1: pc<=branch_target; ifid_valid<=0. Overrides stall.
  3. halt_req=1: state<=HALT; ifid_valid<=0; pc holds (the current fetch is re-fetched after resume).
  4. stall=1: pc, ifid_* and fetch_count hold.
  5. Otherwise: ifid_inst<=rom_data; ifid_pc<=pc; ifid_pc4<=pc+4; ifid_valid<=1; pc<=pc+4; fetch_count<=fetch_count+1 (wraps).
- int_ack is high for exactly one cycle per taken interrupt. int_req held for N cycles is taken on every such cycle; the source must deassert on int_ack.
- HALT:
  - int_req=1: acts as priority 1 above (epc=pc), then state<=RUN.
  - Else resume=1: state<=RUN, and the next cycle fetches pc.
  - Otherwise stall, branch and halt_req are ignored and ifid_valid stays 0.
- BOOT ignores all requests.
- fetch_count increments only on rule 5.
- When ifid_valid=0, the ifid_inst/pc contents are don't-care to downstream but must still be deterministic: they keep their last value.

Test Plan:
1. Reset release, ROM word n = n, 5 free-running cycles -> BOOT 1 cycle with rom_sel=0; then ifid_inst=0,1,2,3; ifid_pc=0,4,8,12; fetch_count=4.
2. Stall asserted for 3 cycles at pc=0x10 -> rom_addr stays 4, ifid_* and fetch_count frozen; after release, fetch resumes at word 4 with no skipped or duplicated instruction.
3. branch_taken with branch_target=0x103 during stall at pc=0x20 -> next pc=0x100, ifid_valid=0 for one cycle, then ifid_pc=0x100.
4. int_req together with branch_taken (target 0x40) at pc=0x30 -> pc=INT_VECTOR (0x800), epc=0x40, int_ack pulses 1 cycle, ifid_valid=0 for one cycle, next ifid_pc=0x800.
5. halt_req at pc=0x14 -> halted=1, rom_sel=0, ifid_valid=0, stall and branch ignored; resume -> ifid_pc=0x14 one cycle after re-entering RUN; int_req in HALT -> epc=0x14, pc=0x800.
6. rst_n pulsed low mid-run at pc=0x7FC -> all outputs return to reset values immediately (asynchronously); fetch restarts at RESET_PC after BOOT. Also, a pc at 0xFFC increments to 0x1000, giving rom_addr=0 (wrap).
